// File: rtl/g_hamming_decoder_pipe.sv
// Two-stage pipelined SECDED decoder. Stage 1 registers syndrome and parity; stage 2 corrects, flags and extracts.
// Define G_HAMDEC_ERR_CNT_EN to add saturating single/double error counters with a synchronous clear.

package g_hamming_pkg;
  // Smallest r with 2^r >= data_w + r + 1.
  function automatic int ecc_bits(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction
endpackage

module g_hamming_decoder_pipe
  import g_hamming_pkg::*;
#(
  parameter int  p_dataSize = 10,
  localparam int R  = ecc_bits(p_dataSize),
  localparam int N  = p_dataSize + R,
  localparam int W  = N + 1,
  localparam int PW = $clog2(W + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [p_dataSize-1:0] out_data,
  output logic                  out_single_err,
  output logic                  out_double_err,
  output logic [PW-1:0]         out_err_pos
`ifdef G_HAMDEC_ERR_CNT_EN
  ,
  input  logic                  clr_cnt,
  output logic [15:0]           err_cnt_single,
  output logic [15:0]           err_cnt_double
`endif
);

  logic                  s1_valid_q, s1_valid_d;
  logic [W-1:0]          s1_code_q, s1_code_d;
  logic [R-1:0]          s1_syn_q, s1_syn_d;
  logic                  s1_par_q, s1_par_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [p_dataSize-1:0] out_data_q, out_data_d;
  logic                  out_single_q, out_single_d;
  logic                  out_double_q, out_double_d;
  logic [PW-1:0]         out_pos_q, out_pos_d;

  logic                  s1_adv, s2_adv;
  logic [R-1:0]          syn;
  logic [W-1:0]          code_fix;
  logic [p_dataSize-1:0] data_x;
  logic                  single_x, double_x;
  logic [PW-1:0]         pos_x;
  int                    syn_i;
  int                    idx;

  // Stage 1: handshake and syndrome/parity capture.
  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    s2_adv = ~s2_valid_q | out_ready;
    s1_adv = ~s1_valid_q | s2_adv;
    syn    = '0;
    for (int p = 1; p <= N; p++)
      for (int k = 0; k < R; k++)
        if (((p >> k) & 1) != 0) syn[k] = syn[k] ^ in_code[p-1];
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s1_code_d  = s1_code_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    if (in_valid && s1_adv) begin
      s1_code_d = in_code;
      s1_syn_d  = syn;
      s1_par_d  = ^in_code;
    end
  end

  assign in_ready = s1_adv;

  // Stage 2: classify, correct, extract data bits from non-power-of-2 positions.
  always_comb begin
    code_fix = s1_code_q;
    single_x = 1'b0;
    double_x = 1'b0;
    pos_x    = '0;
    syn_i    = int'(s1_syn_q);
    if (syn_i == 0) begin
      if (s1_par_q) begin
        single_x = 1'b1;
        pos_x    = PW'(W);
      end
    end else if (!s1_par_q || syn_i > N) begin
      double_x = 1'b1;
    end else begin
      single_x = 1'b1;
      pos_x    = PW'(s1_syn_q);
      for (int p = 1; p <= N; p++)
        if (p == syn_i) code_fix[p-1] = ~code_fix[p-1];
    end

    data_x = '0;
    idx    = 0;
    for (int p = 1; p <= N; p++)
      if ((p & (p - 1)) != 0) begin
        data_x[idx] = code_fix[p-1];
        idx++;
      end

    s2_valid_d   = s2_adv ? s1_valid_q : s2_valid_q;
    out_data_d   = out_data_q;
    out_single_d = out_single_q;
    out_double_d = out_double_q;
    out_pos_d    = out_pos_q;
    if (s2_adv && s1_valid_q) begin
      out_data_d   = data_x;
      out_single_d = single_x;
      out_double_d = double_x;
      out_pos_d    = pos_x;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s2_valid_q   <= 1'b0;
      out_data_q   <= '0;
      out_single_q <= 1'b0;
      out_double_q <= 1'b0;
      out_pos_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      s2_valid_q   <= s2_valid_d;
      out_data_q   <= out_data_d;
      out_single_q <= out_single_d;
      out_double_q <= out_double_d;
      out_pos_q    <= out_pos_d;
    end
  end

  assign out_valid      = s2_valid_q;
  assign out_data       = out_data_q;
  assign out_single_err = out_single_q;
  assign out_double_err = out_double_q;
  assign out_err_pos    = out_pos_q;

`ifdef G_HAMDEC_ERR_CNT_EN
  logic [15:0] cnt_single_q, cnt_single_d;
  logic [15:0] cnt_double_q, cnt_double_d;
  logic        fire;

  // Clear has priority over a same-cycle increment.
  always_comb begin
    fire         = s2_valid_q & out_ready;
    cnt_single_d = cnt_single_q;
    cnt_double_d = cnt_double_q;
    if (clr_cnt) begin
      cnt_single_d = '0;
      cnt_double_d = '0;
    end else if (fire) begin
      if (out_single_q && cnt_single_q != 16'hFFFF) cnt_single_d = cnt_single_q + 16'd1;
      if (out_double_q && cnt_double_q != 16'hFFFF) cnt_double_d = cnt_double_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_single_q <= '0;
      cnt_double_q <= '0;
    end else begin
      cnt_single_q <= cnt_single_d;
      cnt_double_q <= cnt_double_d;
    end
  end

  assign err_cnt_single = cnt_single_q;
  assign err_cnt_double = cnt_double_q;
`endif

endmodule

// File: tb/tb_g_hamming_decoder_pipe.sv
// Self-checking bench for g_hamming_decoder_pipe (p_dataSize=10): scoreboard of expected results, directed steps.
// Counter checks are compiled in when G_HAMDEC_ERR_CNT_EN is defined.

module tb_g_hamming_decoder_pipe;

  typedef struct packed {
    logic [9:0] data;
    logic       single;
    logic       dbl;
    logic [3:0] pos;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_code;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_data;
  logic        out_single_err;
  logic        out_double_err;
  logic [3:0]  out_err_pos;
`ifdef G_HAMDEC_ERR_CNT_EN
  logic        clr_cnt;
  logic [15:0] err_cnt_single;
  logic [15:0] err_cnt_double;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out;
  int   wi;
  logic acc;
  res_t exp_cur;
  res_t sb[$];

  g_hamming_decoder_pipe #(.p_dataSize(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_single_err(out_single_err), .out_double_err(out_double_err), .out_err_pos(out_err_pos)
`ifdef G_HAMDEC_ERR_CNT_EN
    , .clr_cnt(clr_cnt), .err_cnt_single(err_cnt_single), .err_cnt_double(err_cnt_double)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // Reference encoder: data at non-power-of-2 positions, even parity groups, overall parity on top.
  function automatic logic [14:0] enc(input logic [9:0] d);
    logic [14:0] c;
    logic        b;
    int          idx;
    c   = '0;
    idx = 0;
    for (int p = 1; p <= 14; p++)
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[idx];
        idx++;
      end
    for (int k = 0; k < 4; k++) begin
      b = 1'b0;
      for (int p = 1; p <= 14; p++)
        if (((p >> k) & 1) != 0) b = b ^ c[p-1];
      c[(1 << k) - 1] = b;
    end
    c[14] = ^c[13:0];
    return c;
  endfunction

  function automatic logic [9:0] extract(input logic [14:0] c);
    logic [9:0] d;
    int         idx;
    d   = '0;
    idx = 0;
    for (int p = 1; p <= 14; p++)
      if ((p & (p - 1)) != 0) begin
        d[idx] = c[p-1];
        idx++;
      end
    return d;
  endfunction

  function automatic res_t mk(input logic [9:0] d, input logic s, input logic db, input logic [3:0] pos);
    res_t r;
    r.data = d; r.single = s; r.dbl = db; r.pos = pos;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes just before the edge, update scoreboard, return at the next negedge.
  task automatic tick();
    res_t e;
    #1;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      e = (sb.size() != 0) ? sb.pop_front() : res_t'('1);
      check("sb_out", {out_data, out_single_err, out_double_err, out_err_pos}, e);
      n_out++;
    end
    if (acc) sb.push_back(exp_cur);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_one(input logic [14:0] code, input res_t e, input string tag);
    in_valid = 1'b1; in_code = code; exp_cur = e; out_ready = 1'b1;
    tick();
    check({tag, "_acc"}, acc, 1);
    in_valid = 1'b0;
    check({tag, "_lat1"}, out_valid, 0);
    tick();
    check({tag, "_lat2"}, out_valid, 1);
    tick();
  endtask

  task automatic stream(input logic [14:0] code, input res_t e, input int count);
    wi = 0; n_out = 0; out_ready = 1'b1; in_code = code; exp_cur = e;
    for (int cyc = 0; cyc < count + 64 && n_out < count; cyc++) begin
      in_valid = (wi < count);
      tick();
      if (acc) wi++;
    end
    in_valid = 1'b0;
    check("stream_count", n_out, count);
  endtask

  logic [9:0]  bp [5] = '{10'h3C1, 10'h07E, 10'h2D4, 10'h111, 10'h3FF};
  logic [14:0] code;
  logic [9:0]  rd;
  int          ep;
  logic        have;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_code = '0; exp_cur = '0;
`ifdef G_HAMDEC_ERR_CNT_EN
    clr_cnt = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", {out_data, out_single_err, out_double_err, out_err_pos}, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Clean, single errors, parity-bit error, double and invalid-syndrome cases.
    send_one(enc(10'h2A5), mk(10'h2A5, 0, 0, 0), "clean");
    send_one(enc(10'h2A5) ^ 15'h0040, mk(10'h2A5, 1, 0, 4'd7), "single7");
    send_one(enc(10'h2A5) ^ 15'h4000, mk(10'h2A5, 1, 0, 4'd15), "single15");
    code = enc(10'h155) ^ 15'h0204;
    send_one(code, mk(extract(code), 0, 1, 0), "double");
    send_one(enc(10'h2A5) ^ 15'h408B, mk(10'h2A5, 0, 1, 0), "syn_gt_n");

    // Back-pressure: consumer stalls four cycles while five words are offered.
    wi = 0; n_out = 0;
    for (int cyc = 0; cyc < 40 && n_out < 5; cyc++) begin
      out_ready = (cyc >= 4);
      in_valid  = (wi < 5);
      in_code   = enc(bp[wi % 5]);
      exp_cur   = mk(bp[wi % 5], 0, 0, 0);
      #1;
      if (cyc == 2) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_accepted", wi, 2);
      end
      if (cyc == 2 || cyc == 3) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data", out_data, bp[0]);
      end
      tick();
      if (acc) wi++;
    end
    in_valid = 1'b0;
    check("bp_delivered", n_out, 5);
    check("bp_sb_empty", sb.size(), 0);

    // Random data with random single-bit error position (0 = none), random consumer stalls.
    wi = 0; n_out = 0; have = 1'b0;
    for (int cyc = 0; cyc < 300 && n_out < 10; cyc++) begin
      if (!have && wi < 10) begin
        rd = 10'($urandom);
        ep = $urandom_range(15, 0);
        code = enc(rd);
        if (ep != 0) code[ep-1] = ~code[ep-1];
        in_code = code;
        exp_cur = mk(rd, ep != 0, 1'b0, 4'(ep));
        have = 1'b1;
      end
      in_valid  = have;
      out_ready = 1'($urandom_range(1, 0));
      tick();
      if (acc) begin
        have = 1'b0;
        wi++;
      end
    end
    in_valid = 1'b0;
    check("rnd_delivered", n_out, 10);

    // Reset with both stages full.
    out_ready = 1'b0; in_valid = 1'b1;
    in_code = enc(10'h0F0); exp_cur = mk(10'h0F0, 0, 0, 0);
    tick();
    in_code = enc(10'h30C); exp_cur = mk(10'h30C, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    #1;
    check("rstm_full_valid", out_valid, 1);
    check("rstm_full_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rstm_out_valid", out_valid, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_one(enc(10'h1E7) ^ 15'h0001, mk(10'h1E7, 1, 0, 4'd1), "after_rst");

`ifdef G_HAMDEC_ERR_CNT_EN
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("cnt_clr_s", err_cnt_single, 0);
    check("cnt_clr_d", err_cnt_double, 0);

    stream(enc(10'h0AA) ^ 15'h0100, mk(10'h0AA, 1, 0, 4'd9), 3);
    code = enc(10'h3C3) ^ 15'h0011;
    stream(code, mk(extract(code), 0, 1, 0), 2);
    check("cnt_single_3", err_cnt_single, 3);
    check("cnt_double_2", err_cnt_double, 2);

    in_valid = 1'b1; in_code = enc(10'h055) ^ 15'h0008; exp_cur = mk(10'h055, 1, 0, 4'd4);
    tick();
    in_valid = 1'b0;
    tick();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("cnt_clr_win_s", err_cnt_single, 0);
    check("cnt_clr_win_d", err_cnt_double, 0);

    stream(enc(10'h200) ^ 15'h0002, mk(10'h200, 1, 0, 4'd2), 65534);
    check("cnt_fffe", err_cnt_single, 16'hFFFE);
    stream(enc(10'h200) ^ 15'h0002, mk(10'h200, 1, 0, 4'd2), 2);
    check("cnt_sat", err_cnt_single, 16'hFFFF);
    check("cnt_sat_d", err_cnt_double, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
